// File: rtl/menu_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : menu_input_conditioner
// Purpose  : Board pushbutton conditioning for the start menu and paddles.
//            Synchronises the raw active-low buttons into clk_0, debounces
//            each bit, detects presses, masks pulses during a power-on
//            hold-off and emits single-cycle up/down/start pulses plus
//            clean held levels.
// Options  : define AUTO_REPEAT_EN to add auto-repeat on the up/down groups.
// Revision : 1.0 - initial release
// ============================================================================
module menu_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int HOLDOFF_CYCLES  = 1000000,
    parameter int REPEAT_DELAY    = 12500000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic       clk_0,
    input  logic       rst,
    input  logic [4:0] btn_n,
    input  logic       menu_active,
    output logic       up,
    output logic       down,
    output logic       start_trigger,
    output logic [4:0] held
);

    localparam int                 CNT_W     = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam int                 HOLD_W    = $clog2(HOLDOFF_CYCLES + 1);
    localparam logic [HOLD_W-1:0]  HOLD_INIT = HOLD_W'(HOLDOFF_CYCLES);

    // Synchroniser stages (inverted so everything downstream is active-high)
    logic [4:0]            sync1_q, sync1_d;
    logic [4:0]            sync2_q, sync2_d;

    // Debounce state
    logic [4:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [4:0]            held_q, held_d;
    logic [4:0]            held_dly_q, held_dly_d;

    // Power-on hold-off
    logic [HOLD_W-1:0]     holdoff_q, holdoff_d;
    logic                  holdoff_done;

    // Output pulse registers
    logic                  up_q, up_d;
    logic                  down_q, down_d;
    logic                  start_q, start_d;

    logic [4:0]            press;
    logic [1:0]            grp_held;
    logic [1:0]            grp_press;
    logic [1:0]            rep_fire;
    logic                  pulse_ok;
    logic                  up_raw;
    logic                  down_raw;

    // Two-flop synchroniser on the inverted button pins
    always_comb begin
        sync1_d = ~btn_n;
        sync2_d = sync1_q;
    end

    // Per-bit debounce: accept a new level only after DEBOUNCE_CYCLES
    // consecutive samples that disagree with the current held level
    always_comb begin
        cnt_d  = cnt_q;
        held_d = held_q;
        for (int i = 0; i < 5; i++) begin
            if (sync2_q[i] == held_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                held_d[i] = sync2_q[i];
                cnt_d[i]  = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    // Press detection and hold-off countdown (saturates at zero)
    always_comb begin
        held_dly_d   = held_q;
        press        = held_q & ~held_dly_q;
        holdoff_done = (holdoff_q == '0);
        holdoff_d    = holdoff_done ? holdoff_q : holdoff_q - HOLD_W'(1);
        grp_held     = {held_q[1] | held_q[3], held_q[0] | held_q[2]};
        grp_press    = {press[1] | press[3], press[0] | press[2]};
    end

`ifdef AUTO_REPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int REP_W   = $clog2(REP_MAX + 1);
    localparam logic [REP_W-1:0] REP_DLY = REP_W'(REPEAT_DELAY);
    localparam logic [REP_W-1:0] REP_PER = REP_W'(REPEAT_PERIOD);

    // Index 0 is the up group, index 1 the down group
    logic [1:0]            rep_arm_q, rep_arm_d;
    logic [1:0]            rep_phase_q, rep_phase_d;
    logic [1:0][REP_W-1:0] rep_cnt_q, rep_cnt_d;

    // Repeat timers: armed by an unmasked group press, counting cycles
    // since the press (or since the last repeat), cleared on release
    always_comb begin
        rep_arm_d   = rep_arm_q;
        rep_phase_d = rep_phase_q;
        rep_cnt_d   = rep_cnt_q;
        rep_fire    = 2'b00;
        for (int g = 0; g < 2; g++) begin
            if (!grp_held[g]) begin
                rep_arm_d[g]   = 1'b0;
                rep_phase_d[g] = 1'b0;
                rep_cnt_d[g]   = '0;
            end else if (rep_arm_q[g]) begin
                if (rep_cnt_q[g] == (rep_phase_q[g] ? REP_PER : REP_DLY)) begin
                    rep_fire[g]    = 1'b1;
                    rep_phase_d[g] = 1'b1;
                    rep_cnt_d[g]   = REP_W'(1);
                end else begin
                    rep_cnt_d[g] = rep_cnt_q[g] + REP_W'(1);
                end
            end else if (grp_press[g] && holdoff_done) begin
                rep_arm_d[g] = 1'b1;
                rep_cnt_d[g] = REP_W'(1);
            end
        end
    end

    // Repeat timer registers
    always_ff @(posedge clk_0) begin
        if (!rst) begin
            rep_arm_q   <= 2'b00;
            rep_phase_q <= 2'b00;
            rep_cnt_q   <= '0;
        end else begin
            rep_arm_q   <= rep_arm_d;
            rep_phase_q <= rep_phase_d;
            rep_cnt_q   <= rep_cnt_d;
        end
    end
`else
    // Repeat parameters are kept on the interface so both builds share one
    // instantiation; without auto-repeat they only feed this constant.
    localparam bit REPEAT_CFG_SEEN = (REPEAT_DELAY >= 0) || (REPEAT_PERIOD >= 0);
    assign rep_fire = REPEAT_CFG_SEEN ? 2'b00 : 2'b00;
`endif

    // Output pulse formation: gating by menu_active and hold-off, up wins over down
    always_comb begin
        pulse_ok = menu_active & holdoff_done;
        up_raw   = grp_press[0] | rep_fire[0];
        down_raw = grp_press[1] | rep_fire[1];
        up_d     = pulse_ok & up_raw;
        down_d   = pulse_ok & down_raw & ~up_raw;
        start_d  = pulse_ok & press[4];
    end

    // State registers, synchronous active-low reset
    always_ff @(posedge clk_0) begin
        if (!rst) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            cnt_q      <= '0;
            held_q     <= '0;
            held_dly_q <= '0;
            holdoff_q  <= HOLD_INIT;
            up_q       <= 1'b0;
            down_q     <= 1'b0;
            start_q    <= 1'b0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            cnt_q      <= cnt_d;
            held_q     <= held_d;
            held_dly_q <= held_dly_d;
            holdoff_q  <= holdoff_d;
            up_q       <= up_d;
            down_q     <= down_d;
            start_q    <= start_d;
        end
    end

    assign up            = up_q;
    assign down          = down_q;
    assign start_trigger = start_q;
    assign held          = held_q;

endmodule
`default_nettype wire

// File: tb/tb_menu_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : tb_menu_input_conditioner
// Purpose  : Self-checking bench for menu_input_conditioner: directed
//            scenarios with literal expectations plus a randomised run, all
//            compared every cycle against a behavioural reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_menu_input_conditioner;

    localparam int D  = 4;
    localparam int H  = 10;
    localparam int RD = 20;
    localparam int RP = 8;

    logic       clk_0;
    logic       rst;
    logic [4:0] btn_n;
    logic       menu_active;
    logic       up;
    logic       down;
    logic       start_trigger;
    logic [4:0] held;

    int checks = 0;
    int errors = 0;

    menu_input_conditioner #(
        .DEBOUNCE_CYCLES (D),
        .HOLDOFF_CYCLES  (H),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .clk_0         (clk_0),
        .rst           (rst),
        .btn_n         (btn_n),
        .menu_active   (menu_active),
        .up            (up),
        .down          (down),
        .start_trigger (start_trigger),
        .held          (held)
    );

    initial begin
        clk_0 = 1'b0;
        forever #5 clk_0 = ~clk_0;
    end

    task automatic chk(input string name, input logic [4:0] act, input logic [4:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: 2-sample input delay, level accepted when the last
    // D samples all disagree with it, press = new acceptance of a 1,
    // pulses masked until H unreset edges have elapsed, repeats derived
    // from elapsed time since the arming press.
    // ------------------------------------------------------------------
    logic [4:0] m_pipe[$];
    logic [4:0] m_win[$];
    logic [4:0] m_held      = '0;
    logic [4:0] m_held_prev = '0;
    int         m_cycle     = 0;
    int         m_since_rst = 0;
    bit         m_arm[2];
    int         m_arm_t[2];
    logic       m_up        = 1'b0;
    logic       m_down      = 1'b0;
    logic       m_start     = 1'b0;
    bit         m_valid     = 1'b0;

    always @(posedge clk_0) begin : model
        logic [4:0] press;
        logic [4:0] syncv;
        bit         expired;
        bit         all_diff;
        bit [1:0]   gh;
        bit [1:0]   gp;
        bit [1:0]   rep;
        int         el;
        if (!rst) begin
            m_pipe.delete();
            m_pipe.push_back(5'b0);
            m_pipe.push_back(5'b0);
            m_win.delete();
            m_held      = '0;
            m_held_prev = '0;
            m_since_rst = 0;
            m_arm[0]    = 1'b0;
            m_arm[1]    = 1'b0;
            m_up        = 1'b0;
            m_down      = 1'b0;
            m_start     = 1'b0;
            m_valid     = 1'b1;
        end else if (m_valid) begin
            press   = m_held & ~m_held_prev;
            expired = (m_since_rst >= H);
            gh      = {m_held[1] | m_held[3], m_held[0] | m_held[2]};
            gp      = {press[1] | press[3], press[0] | press[2]};
            rep     = 2'b00;
            for (int g = 0; g < 2; g++) begin
                if (!gh[g]) begin
                    m_arm[g] = 1'b0;
                end else if (m_arm[g]) begin
                    el = m_cycle - m_arm_t[g];
`ifdef AUTO_REPEAT_EN
                    rep[g] = (el == RD) || (el > RD && ((el - RD) % RP) == 0);
`endif
                end else if (gp[g] && expired) begin
                    m_arm[g]   = 1'b1;
                    m_arm_t[g] = m_cycle;
                end
            end
            m_up    = menu_active & expired & (gp[0] | rep[0]);
            m_down  = menu_active & expired & (gp[1] | rep[1]) & ~(gp[0] | rep[0]);
            m_start = menu_active & expired & press[4];

            m_held_prev = m_held;
            syncv = m_pipe.pop_front();
            m_pipe.push_back(~btn_n);
            m_win.push_back(syncv);
            if (m_win.size() > D) void'(m_win.pop_front());
            if (m_win.size() == D) begin
                for (int i = 0; i < 5; i++) begin
                    all_diff = 1'b1;
                    for (int j = 0; j < D; j++)
                        if (m_win[j][i] == m_held_prev[i]) all_diff = 1'b0;
                    if (all_diff) m_held[i] = ~m_held_prev[i];
                end
            end
            m_since_rst++;
        end
        m_cycle++;
    end

    // Per-cycle comparison of every output against the model
    always @(negedge clk_0) begin
        if (m_valid) begin
            chk("model_up",    5'(up),            5'(m_up));
            chk("model_down",  5'(down),          5'(m_down));
            chk("model_start", 5'(start_trigger), 5'(m_start));
            chk("model_held",  held,              m_held);
        end
    end

    task automatic do_reset();
        rst = 1'b0;
        @(negedge clk_0);
        rst = 1'b1;
    endtask

    task automatic count_pulses(input int n, output int nu, output int nd, output int ns);
        nu = 0; nd = 0; ns = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk_0);
            if (up === 1'b1)            nu++;
            if (down === 1'b1)          nd++;
            if (start_trigger === 1'b1) ns++;
        end
    endtask

    initial begin : stim
        int nu, nd, ns, bu, bd, bs;
        rst         = 1'b0;
        btn_n       = 5'b11111;
        menu_active = 1'b1;
        repeat (3) @(negedge clk_0);
        chk("reset_held",  held,              5'b00000);
        chk("reset_up",    5'(up),            5'b0);
        chk("reset_down",  5'(down),          5'b0);
        chk("reset_start", 5'(start_trigger), 5'b0);
        rst = 1'b1;
        repeat (12) @(negedge clk_0);

        // Clean press of P1 up: next rising edge is edge 0
        btn_n = 5'b11110;
        for (int k = 0; k <= 8; k++) begin
            @(negedge clk_0);
            chk("clean_up",    5'(up),      5'(k == 6));
            chk("clean_held0", 5'(held[0]), 5'(k >= 5));
            if (k == 6) begin
                chk("clean_down",  5'(down),          5'b0);
                chk("clean_start", 5'(start_trigger), 5'b0);
            end
        end
        btn_n = 5'b11111;
        repeat (10) @(negedge clk_0);

        // Bouncing start button, then held low
        bs = 0;
        for (int r = 0; r < 3; r++) begin
            btn_n[4] = 1'b0;
            count_pulses(3, nu, nd, ns); bs += ns;
            btn_n[4] = 1'b1;
            count_pulses(3, nu, nd, ns); bs += ns;
        end
        chk("bounce_none", 5'(bs), 5'd0);
        btn_n[4] = 1'b0;
        count_pulses(10, nu, nd, ns);
        chk("bounce_one", 5'(ns), 5'd1);
        btn_n = 5'b11111;
        repeat (10) @(negedge clk_0);

        // Hold-off masks a press made right after reset
        do_reset();
        repeat (2) @(negedge clk_0);
        btn_n[1] = 1'b0;
        count_pulses(20, nu, nd, ns);
        chk("holdoff_masked", 5'(nd), 5'd0);
        btn_n[1] = 1'b1;
        repeat (8) @(negedge clk_0);
        btn_n[1] = 1'b0;
        count_pulses(10, nu, nd, ns);
        chk("holdoff_repress", 5'(nd), 5'd1);
        btn_n = 5'b11111;
        repeat (10) @(negedge clk_0);

        // Simultaneous P2 up and P2 down
        btn_n = 5'b10011;
        count_pulses(10, nu, nd, ns);
        chk("simul_up",   5'(nu), 5'd1);
        chk("simul_down", 5'(nd), 5'd0);
        btn_n = 5'b11111;
        repeat (10) @(negedge clk_0);
        menu_active = 1'b0;
        btn_n = 5'b10011;
        count_pulses(10, nu, nd, ns);
        chk("gated_up",   5'(nu), 5'd0);
        chk("gated_down", 5'(nd), 5'd0);
        chk("gated_held", held, 5'b01100);
        btn_n = 5'b11111;
        menu_active = 1'b1;
        repeat (10) @(negedge clk_0);

        // Reset two cycles into a debounce
        btn_n[0] = 1'b0;
        repeat (3) @(negedge clk_0);
        rst = 1'b0;
        @(negedge clk_0);
        chk("midrst_up",    5'(up),            5'b0);
        chk("midrst_down",  5'(down),          5'b0);
        chk("midrst_start", 5'(start_trigger), 5'b0);
        chk("midrst_held",  held,              5'b00000);
        rst = 1'b1;
        count_pulses(25, nu, nd, ns);
        chk("midrst_no_up", 5'(nu), 5'd0);
        btn_n = 5'b11111;
        repeat (12) @(negedge clk_0);

        // Long hold of P1 up
        btn_n[0] = 1'b0;
        count_pulses(55, nu, nd, ns);
`ifdef AUTO_REPEAT_EN
        chk("hold_pulses", 5'(nu), 5'd5);
`else
        chk("hold_pulses", 5'(nu), 5'd1);
`endif
        btn_n = 5'b11111;
        repeat (10) @(negedge clk_0);

        // Randomised run with occasional resets and menu toggles
        bu = 0; bd = 0;
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < 5; i++)
                if ($urandom_range(5, 0) == 0) btn_n[i] = ~btn_n[i];
            if ($urandom_range(24, 0) == 0) menu_active = ~menu_active;
            rst = ($urandom_range(399, 0) != 0);
            @(negedge clk_0);
            if (up === 1'b1 && down === 1'b1) bd++;
            if (up === 1'b1) bu++;
        end
        chk("random_up_down_exclusive", 5'(bd), 5'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/menu_input_conditioner.md
# menu_input_conditioner

Converts the raw, asynchronous board pushbuttons into clean single-cycle command pulses (`up`, `down`, `start_trigger`) for the start menu, and clean held levels for the in-game paddle logic. Sits directly between the board button pins and the start-menu / paddle-control blocks, in the `clk_0` pixel-clock domain. Provides synchronisation, per-button debounce, rising-edge detection, a power-on start hold-off and, optionally, auto-repeat on the navigation buttons.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, 250000: consecutive stable samples needed to accept a level change (10 ms at 25 MHz); ≥2.
- `HOLDOFF_CYCLES`, 1000000: cycles after reset during which all pulses are masked; ≥1.
- `REPEAT_DELAY`, 12500000: held cycles before the first auto-repeat pulse (used only with `AUTO_REPEAT_EN`).
- `REPEAT_PERIOD`, 5000000: cycles between later auto-repeat pulses (used only with `AUTO_REPEAT_EN`).

Ports:
- `clk_0`  in  1  pixel clock; all logic is on its rising edge.
- `rst`  in  1  reset: synchronous, active-low. Clock is `clk_0`.
- `btn_n`  in  5  raw buttons, active-low, asynchronous: [0] P1 up, [1] P1 down, [2] P2 up, [3] P2 down, [4] start.
- `menu_active`  in  1  1 = menu pulses enabled; 0 = `up`/`down`/`start_trigger` forced to 0.
- `up`  out  1  one-cycle pulse: P1-up or P2-up press.
- `down`  out  1  one-cycle pulse: P1-down or P2-down press.
- `start_trigger`  out  1  one-cycle pulse: start-button press.
- `held`  out  5  debounced, active-high levels, same bit order as `btn_n`.

## Operation
- **Synchroniser:** each `btn_n` bit is inverted, then passes through a 2-flop synchroniser to give `sync[i]`.
- **Debounce (per bit):** counter `cnt[i]`, width `$clog2(DEBOUNCE_CYCLES)`.
  - If `sync[i] == held[i]`: `cnt[i]` ← 0.
  - Else if `cnt[i] == DEBOUNCE_CYCLES-1`: `held[i]` ← `sync[i]` and `cnt[i]` ← 0.
  - Else: `cnt[i]` increments.
  - A glitch shorter than `DEBOUNCE_CYCLES` samples never reaches `held`.
- **Press detect:** `press[i] = held[i] & ~held_d[i]`, where `held_d` is `held` delayed by one register. Releases generate nothing.
- **Hold-off counter:**
  - Loads `HOLDOFF_CYCLES` on reset and counts down to 0, then stops.
  - While it is non-zero, all `press` are masked.
  - A button already held when hold-off expires produces no pulse until it is released and pressed again.
- **Output pulses:**
  - Raw outputs: `up_r = press[0] | press[2]`, `down_r = press[1] | press[3]`, `start_r = press[4]`.
  - Registered outputs are gated by `menu_active` and hold-off expiry.
  - **Simultaneous up and down in the same cycle:** `up` is asserted and `down` is suppressed, so the two are never high together.
  - **Start together with up/down:** both pulses are emitted in the same cycle; the consumer resolves ordering.
- **`held`:** never gated by `menu_active` or hold-off.

## Timing
- **Reset:** `held`=0, `held_d`=0, all `cnt`=0, synchroniser flops=0, `up`=`down`=`start_trigger`=0, hold-off=`HOLDOFF_CYCLES`, repeat counters=0.
- **Reset mid-operation:** everything returns to the values above on the next edge. Any in-progress debounce is discarded.
- **Latency, edge numbering:** the first edge at which the synchroniser stage-1 flop samples the new level is edge 0.
  - `sync` changes after edge 1.
  - `held` changes after edge 1+`DEBOUNCE_CYCLES`.
  - The pulse is high for exactly one cycle, after edge 2+`DEBOUNCE_CYCLES`.
- **`menu_active` gating:** sampled combinationally into the output register in the same cycle as `press`. Deasserting it drops any pulse on the next edge.
- **Counter wrap:** none. Debounce counters clear on acceptance; the hold-off counter saturates at 0.

## Configuration
- `AUTO_REPEAT_EN` defined:
  - A repeat counter runs for up (`held[0]|held[2]`) and one for down (`held[1]|held[3]`).
  - While the group stays held, an extra pulse is emitted `REPEAT_DELAY` cycles after the press pulse, then every `REPEAT_PERIOD` cycles.
  - A counter clears when its group releases.
  - Repeats obey the same gating and up-over-down priority as press pulses.
  - Start never repeats.
- `AUTO_REPEAT_EN` undefined: exactly one pulse per press. The repeat logic and the `REPEAT_*` parameters are unused.

## Test plan
Benches use `DEBOUNCE_CYCLES`=4, `HOLDOFF_CYCLES`=10, `REPEAT_DELAY`=20, `REPEAT_PERIOD`=8.
- **Clean press:** after hold-off, drive `btn_n[0]`=0 steadily with `menu_active`=1 → `up`=1 for exactly one cycle, 6 edges after the first sampling edge; `held[0]`=1; `down`=`start_trigger`=0.
- **Bounce:** toggle `btn_n[4]` with 3-cycle pulses, then hold low → no `start_trigger` during the bounce; one pulse once low has been stable for 4 samples.
- **Hold-off:** press `btn_n[1]` at cycle 2 after reset and keep it held → no `down`; release and re-press after cycle 20 → one `down` pulse.
- **Simultaneous press:** `btn_n[2]` and `btn_n[3]` go low on the same edge → `up`=1, `down`=0. With `menu_active`=0 the same stimulus gives no pulses, but `held`=5'b01100.
- **Reset mid-debounce:** assert `rst`=0 two cycles into the debounce of `btn_n[0]` → all outputs 0 on the next edge; no `up` pulse after `rst` returns high.
- **`AUTO_REPEAT_EN` hold:** hold `btn_n[0]` for 50 cycles → `up` pulses at press, press+20, press+28, press+36, press+44. Without the macro, a single pulse.
